// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ burst requesters.
// Optional stalled-grant watchdog enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    input  logic                     fifo_almost_full,
    output logic                     fifo_we,
    output logic [DW-1:0]            fifo_wdata,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("fifo_wr_arbiter: unsupported NREQ/TIMEOUT configuration");
    end

    typedef enum logic {IDLE, BURST} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            fifo_we_q, fifo_we_d;
    logic [DW-1:0]   fifo_wdata_q, fifo_wdata_d;

    logic            accept_ok;
    logic            valid_g;
    logic            last_g;
    logic [DW-1:0]   beat_g;
    logic            hs;
    logic            found;
    logic [IW-1:0]   sel;
    logic [IW:0]     idx;
    logic [IW:0]     ptr_inc;
    logic            tmo_fire;

    // Last free slot is reserved for the write already sitting in the output stage.
    assign accept_ok = !fifo_full && !(fifo_almost_full && fifo_we_q);
    assign valid_g   = req_valid[grant_id_q];
    assign last_g    = req_last[grant_id_q];
    assign hs        = (state_q == BURST) && valid_g && accept_ok;

    always_comb begin
        beat_g = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id_q == IW'(i)) beat_g = req_data[i*DW +: DW];
        end
    end

    // Rotating search from rr_ptr; explicit subtract keeps non-power-of-two NREQ correct.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!found && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                sel   = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        ptr_inc = {1'b0, grant_id_q} + (IW+1)'(1);
        if (ptr_inc == NREQ_W) ptr_inc = '0;
    end

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_err_q;

    always_comb begin
        tmo_cnt_d = '0;
        tmo_fire  = 1'b0;
        if (state_q == BURST && !valid_g) begin
            if (tmo_cnt_q == CW'(TIMEOUT-1)) begin
                tmo_fire = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= tmo_fire;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        fifo_we_d    = 1'b0;
        fifo_wdata_d = fifo_wdata_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = sel;
                    state_d    = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id_q] = accept_ok;
                if (hs) begin
                    fifo_we_d    = 1'b1;
                    fifo_wdata_d = beat_g;
                    if (last_g) begin
                        state_d  = IDLE;
                        rr_ptr_d = ptr_inc[IW-1:0];
                    end
                end else if (tmo_fire) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_inc[IW-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            fifo_we_q    <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            fifo_we_q    <= fifo_we_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

    assign fifo_we    = fifo_we_q;
    assign fifo_wdata = fifo_wdata_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DW=32, TIMEOUT=16).
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full = 1'b0;
    logic              fifo_almost_full = 1'b0;
    logic              fifo_we;
    logic [DW-1:0]     fifo_wdata;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_last         (req_last),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_we          (fifo_we),
        .fifo_wdata       (fifo_wdata),
        .grant_id         (grant_id),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        check("rst_we", fifo_we, 0);
        check("rst_wdata", fifo_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_ready", req_ready, 0);
        check("rst_terr", timeout_err, 0);

        // Fairness: all valid, single-beat bursts
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_data(i, 32'hA000_0000 + i);
        for (int k = 0; k < 5; k++) begin
            step();
            check("fair_grant", grant_id, k % 4);
            check("fair_busy", busy, 1);
            check("fair_we_idle", fifo_we, 0);
            check("fair_ready", req_ready, 4'b0001 << (k % 4));
            if (k < 4) begin
                step();
                check("fair_we", fifo_we, 1);
                check("fair_wdata", fifo_wdata, 32'hA000_0000 + k);
                check("fair_idle", busy, 0);
            end
        end

        // Burst lock: req1 3-beat burst, req2 waiting
        do_reset();
        req_valid = 4'b0110;
        req_last  = 4'b0100;
        set_data(1, 32'h0000_00A1);
        set_data(2, 32'h0000_00B2);
        step();
        check("lock_grant0", grant_id, 1);
        check("lock_ready", req_ready, 4'b0010);
        step();
        check("lock_we1", fifo_we, 1);
        check("lock_d1", fifo_wdata, 32'hA1);
        check("lock_grant1", grant_id, 1);
        set_data(1, 32'h0000_00A2);
        step();
        check("lock_d2", fifo_wdata, 32'hA2);
        check("lock_grant2", grant_id, 1);
        set_data(1, 32'h0000_00A3);
        req_last[1] = 1'b1;
        step();
        check("lock_we3", fifo_we, 1);
        check("lock_d3", fifo_wdata, 32'hA3);
        check("lock_grant3", grant_id, 1);
        check("lock_idle", busy, 0);
        req_valid[1] = 1'b0;
        step();
        check("lock_grant_r2", grant_id, 2);
        check("lock_we_gap", fifo_we, 0);
        step();
        check("lock_d_r2", fifo_wdata, 32'hB2);

        // Backpressure: one free slot then full
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        fifo_almost_full = 1'b1;
        set_data(0, 32'h0000_00D0);
        step();
        check("bp_ready0", req_ready, 4'b0001);
        step();
        check("bp_we0", fifo_we, 1);
        check("bp_d0", fifo_wdata, 32'hD0);
        check("bp_ready_af", req_ready, 4'b0000);
        fifo_full = 1'b1;
        fifo_almost_full = 1'b0;
        set_data(0, 32'h0000_00D1);
        #1;
        check("bp_ready_full", req_ready, 4'b0000);
        repeat (2) begin
            step();
            check("bp_we_full", fifo_we, 0);
            check("bp_ready_hold", req_ready, 4'b0000);
            check("bp_d_hold", fifo_wdata, 32'hD0);
        end
        fifo_full = 1'b0;
        #1;
        check("bp_ready_back", req_ready, 4'b0001);
        step();
        check("bp_we1", fifo_we, 1);
        check("bp_d1", fifo_wdata, 32'hD1);

        // Wrap and gaps: move rr_ptr to 2, then only req3 and req1
        do_reset();
        req_valid = 4'b0010;
        req_last  = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_data(i, 32'hC000_0000 + i);
        step();
        check("wrap_pre", grant_id, 1);
        step();
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("wrap_grant", grant_id, (k % 2 == 0) ? 3 : 1);
            step();
            check("wrap_wdata", fifo_wdata, 32'hC000_0000 + ((k % 2 == 0) ? 3 : 1));
        end

        // Reset mid-burst
        do_reset();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        set_data(2, 32'h0000_0E2E);
        step();
        step();
        check("mid_we_pre", fifo_we, 1);
        check("mid_grant_pre", grant_id, 2);
        #2 rst = 1'b0;
        #1;
        check("mid_we", fifo_we, 0);
        check("mid_busy", busy, 0);
        check("mid_grant", grant_id, 0);
        check("mid_ready", req_ready, 0);
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        set_data(0, 32'h0000_0F00);
        step();
        check("mid_we_hold", fifo_we, 0);
        step();
        rst = 1'b1;
        step();
        check("mid_restart", grant_id, 0);
        step();
        check("mid_restart_d", fifo_wdata, 32'hF00);

        // Stalled grant
        do_reset();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        step();
        check("tmo_grant", grant_id, 2);
        req_valid = 4'b1000;
        repeat (15) step();
        check("tmo_pre_terr", timeout_err, 0);
        check("tmo_pre_busy", busy, 1);
        step();
`ifdef FIFO_ARB_TIMEOUT_EN
        check("tmo_terr", timeout_err, 1);
        check("tmo_idle", busy, 0);
        step();
        check("tmo_terr_off", timeout_err, 0);
        check("tmo_grant3", grant_id, 3);
        check("tmo_busy3", busy, 1);
`else
        check("hold_terr", timeout_err, 0);
        check("hold_grant", grant_id, 2);
        check("hold_busy", busy, 1);
        repeat (10) step();
        check("hold_grant_late", grant_id, 2);
        check("hold_ready", req_ready, 4'b0100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
